multichannel_calibration: RTL and testbench

MULTICHANNEL_CALIBRATION -- requirements
Module: multichannel_calibration

---
 rtl/multichannel_calibration.sv | 200 ++++++++++++++++++++
 tb/tb_multichannel_calibration.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_calibration.sv
// multichannel_calibration
//
// Per-channel offset/gain correction of a tagged sample stream. Two pipeline
// stages move together on a single advance enable:
//   stage 1 : s1  = sat(in_data + offset[ch]); gain[ch] and tag latched with it
//   stage 2 : out = gain_enable ? sat(round(s1 * gain)) : s1
// Coefficients live in a small register file written through cal_we/cal_address/
// cal_data, address = {channel, field} with field 0 = offset, field 1 = gain.
//
// Ports
//   clock, reset            sole clock, asynchronous active-high reset
//   in_data/in_channel      signed sample and its channel tag
//   in_valid/in_ready       input handshake (in_ready = advance, forced high on flush)
//   out_data/out_channel    calibrated sample and tag
//   out_saturated           stage-1 or stage-2 clamp hit this sample
//   out_valid/out_ready     output handshake
//   cal_we/cal_address/cal_data  coefficient writes
//   gain_enable             apply the stage-2 gain multiply
//   pipeline_flush          synchronous drop of all in-flight samples
//   sat_count               saturating count of saturated output handshakes

module multichannel_calibration #(
    parameter int DATA_PATH_WIDTH = 16,
    parameter int N_CHANNELS      = 4,
    parameter int CH_W            = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
    parameter int GAIN_FRAC_BITS  = 12
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic signed [DATA_PATH_WIDTH-1:0] in_data,
    input  logic [CH_W-1:0]                   in_channel,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic signed [DATA_PATH_WIDTH-1:0] out_data,
    output logic [CH_W-1:0]                   out_channel,
    output logic                              out_saturated,
    output logic                              out_valid,
    input  logic                              out_ready,
    input  logic                              cal_we,
    input  logic [CH_W:0]                     cal_address,
    input  logic [15:0]                       cal_data,
    input  logic                              gain_enable,
    input  logic                              pipeline_flush,
    output logic [15:0]                       sat_count
);

    localparam int W  = DATA_PATH_WIDTH;
    // product of W-bit signed and 17-bit (zero-extended) gain plus rounding headroom
    localparam int PW = DATA_PATH_WIDTH + 18;

    localparam logic signed [W-1:0] SMAX     = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN     = {1'b1, {(W-1){1'b0}}};
    localparam logic [15:0]         GAIN_ONE = 16'(32'd1 << GAIN_FRAC_BITS);
    localparam logic [PW-1:0]       RND      = PW'(64'd1 << (GAIN_FRAC_BITS - 1));

    // ---------------- coefficient register file ----------------
    logic signed [W-1:0] offset_q [N_CHANNELS];
    logic [15:0]         gain_q   [N_CHANNELS];

    logic [CH_W-1:0]     cal_ch;
    logic                cal_field;
    logic                cal_ch_ok;
    logic signed [W-1:0] cal_off;

    assign cal_ch    = cal_address[CH_W:1];
    assign cal_field = cal_address[0];
    assign cal_ch_ok = ({1'b0, cal_ch} < (CH_W+1)'(N_CHANNELS));

    generate
        if (W <= 16) begin : g_off_narrow
            assign cal_off = cal_data[W-1:0];
        end else begin : g_off_wide
            assign cal_off = {{(W-16){cal_data[15]}}, cal_data};
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                offset_q[i] <= '0;
                gain_q[i]   <= GAIN_ONE;
            end
        end else if (cal_we && cal_ch_ok) begin
            if (!cal_field) offset_q[cal_ch] <= cal_off;
            else            gain_q[cal_ch]   <= cal_data;
        end
    end

    // ---------------- pipeline registers ----------------
    logic                s1_valid_q;
    logic signed [W-1:0] s1_data_q;
    logic [15:0]         s1_gain_q;
    logic [CH_W-1:0]     s1_ch_q;
    logic                s1_sat_q;

    logic                out_valid_q;
    logic signed [W-1:0] out_data_q;
    logic [CH_W-1:0]     out_ch_q;
    logic                out_sat_q;
    logic [15:0]         sat_count_q;

    logic advance;
    assign advance  = ~out_valid_q | out_ready;
    // flush empties everything, so the input side is always free during it
    assign in_ready = advance | pipeline_flush;

    // ---------------- stage 1: offset add ----------------
    logic                in_ch_ok;
    logic signed [W-1:0] off_sel;
    logic [15:0]         gain_sel;
    logic [W:0]          sum1;
    logic                s1_sat_d;
    logic signed [W-1:0] s1_data_d;

    assign in_ch_ok = ({1'b0, in_channel} < (CH_W+1)'(N_CHANNELS));

    always_comb begin
        off_sel  = '0;
        gain_sel = GAIN_ONE;
        if (in_ch_ok) begin
            off_sel  = offset_q[in_channel];
            gain_sel = gain_q[in_channel];
        end
        sum1      = {in_data[W-1], in_data} + {off_sel[W-1], off_sel};
        // overflow when the extra sign bit disagrees with the result sign
        s1_sat_d  = sum1[W] ^ sum1[W-1];
        s1_data_d = s1_sat_d ? (sum1[W] ? SMIN : SMAX) : sum1[W-1:0];
    end

    // ---------------- stage 2: gain multiply ----------------
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rnd_sum;
    logic signed [PW-1:0] shifted;
    logic [PW-W:0]        hi;
    logic                 g_fits;
    logic signed [W-1:0]  g_data;
    logic signed [W-1:0]  s2_data_d;
    logic                 s2_sat_d;

    always_comb begin
        prod    = PW'(s1_data_q) * PW'($signed({1'b0, s1_gain_q}));
        rnd_sum = prod + $signed(RND);
        shifted = rnd_sum >>> GAIN_FRAC_BITS;
        // result fits in W bits when everything from bit W-1 upward is sign copy
        hi      = shifted[PW-1:W-1];
        g_fits  = (&hi) | ~(|hi);
        g_data  = g_fits ? shifted[W-1:0] : (shifted[PW-1] ? SMIN : SMAX);

        s2_data_d = s1_data_q;
        s2_sat_d  = s1_sat_q;
        if (gain_enable) begin
            s2_data_d = g_data;
            s2_sat_d  = s1_sat_q | ~g_fits;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_gain_q   <= GAIN_ONE;
            s1_ch_q     <= '0;
            s1_sat_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_sat_q   <= 1'b0;
            sat_count_q <= '0;
        end else begin
            if (out_valid_q && out_ready && out_sat_q && (sat_count_q != 16'hFFFF))
                sat_count_q <= sat_count_q + 16'd1;

            if (pipeline_flush) begin
                s1_valid_q  <= 1'b0;
                out_valid_q <= 1'b0;
            end else if (advance) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_data_q <= s1_data_d;
                    s1_gain_q <= gain_sel;
                    s1_ch_q   <= in_channel;
                    s1_sat_q  <= s1_sat_d;
                end
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= s2_data_d;
                    out_ch_q   <= s1_ch_q;
                    out_sat_q  <= s2_sat_d;
                end
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_channel   = out_ch_q;
    assign out_saturated = out_sat_q;
    assign sat_count     = sat_count_q;

endmodule

// File: tb/tb_multichannel_calibration.sv
module tb_multichannel_calibration;

    logic               clock;
    logic               reset;
    logic signed [15:0] in_data;
    logic [1:0]         in_channel;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] out_data;
    logic [1:0]         out_channel;
    logic               out_saturated;
    logic               out_valid;
    logic               out_ready;
    logic               cal_we;
    logic [2:0]         cal_address;
    logic [15:0]        cal_data;
    logic               gain_enable;
    logic               pipeline_flush;
    logic [15:0]        sat_count;

    int checks = 0;
    int errors = 0;

    multichannel_calibration #(
        .DATA_PATH_WIDTH(16),
        .N_CHANNELS(4),
        .CH_W(2),
        .GAIN_FRAC_BITS(12)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_data(in_data),
        .in_channel(in_channel),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_channel(out_channel),
        .out_saturated(out_saturated),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .cal_we(cal_we),
        .cal_address(cal_address),
        .cal_data(cal_data),
        .gain_enable(gain_enable),
        .pipeline_flush(pipeline_flush),
        .sat_count(sat_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int   ch;
        int   d;
        logic ge;
        int   exp_d;
        int   exp_sat;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    // called at posedge+1; leaves the bench at posedge+1
    task automatic cal_write(input int addr, input int data);
        cal_we      = 1'b1;
        cal_address = 3'(addr);
        cal_data    = 16'(data);
        @(posedge clock); #1;
        cal_we      = 1'b0;
    endtask

    // single sample through an empty pipeline with out_ready high
    task automatic send(input string nm, input int ch, input int d, input logic ge,
                        input int exp_d, input int exp_sat);
        in_valid    = 1'b1;
        in_channel  = 2'(ch);
        in_data     = 16'(d);
        gain_enable = ge;
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk({nm, "/lat1_valid"}, 32'(out_valid), 0);
        @(posedge clock); #1;
        chk({nm, "/valid"}, 32'(out_valid), 1);
        chk({nm, "/data"}, 32'($signed(out_data)), exp_d);
        chk({nm, "/chan"}, 32'(out_channel), ch);
        chk({nm, "/sat"}, 32'(out_saturated), exp_sat);
    endtask

    int bp_d   [4];
    int bp_exp [4];

    initial begin
        vecs[0]  = '{0,   1000, 1'b1,   1000, 0};
        vecs[1]  = '{1,  32512, 1'b1,  32767, 1};
        vecs[2]  = '{2,  -1000, 1'b1,  -1500, 0};
        vecs[3]  = '{2,      3, 1'b1,      5, 0};
        vecs[4]  = '{2,     -3, 1'b1,     -4, 0};
        vecs[5]  = '{2,      3, 1'b0,      3, 0};
        vecs[6]  = '{2,  30000, 1'b1,  32767, 1};
        vecs[7]  = '{2, -30000, 1'b1, -32768, 1};
        vecs[8]  = '{3,    100, 1'b1,     48, 0};
        vecs[9]  = '{3, -32768, 1'b1, -16384, 1};
        vecs[10] = '{1,   -100, 1'b1,    412, 0};
        vecs[11] = '{1,  32512, 1'b0,  32767, 1};

        bp_d   = '{10, 20, 30, 40};
        bp_exp = '{10, 532, 30, 35};

        reset          = 1'b1;
        in_data        = '0;
        in_channel     = '0;
        in_valid       = 1'b0;
        out_ready      = 1'b1;
        cal_we         = 1'b0;
        cal_address    = '0;
        cal_data       = '0;
        gain_enable    = 1'b1;
        pipeline_flush = 1'b0;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;

        chk("rst/out_valid", 32'(out_valid), 0);
        chk("rst/out_data", 32'($signed(out_data)), 0);
        chk("rst/out_channel", 32'(out_channel), 0);
        chk("rst/out_saturated", 32'(out_saturated), 0);
        chk("rst/sat_count", 32'(sat_count), 0);
        chk("rst/in_ready", 32'(in_ready), 1);

        // pass-through before any calibration write
        send("passthru", 0, 1000, 1'b1, 1000, 0);

        cal_write(2, 16'h0200);   // ch1 offset +512
        cal_write(5, 16'h1800);   // ch2 gain 1.5
        cal_write(6, 16'hFFFB);   // ch3 offset -5
        cal_write(7, 16'h0800);   // ch3 gain 0.5

        for (int i = 0; i < 12; i++) begin
            send($sformatf("vec%0d", i), vecs[i].ch, vecs[i].d, vecs[i].ge,
                 vecs[i].exp_d, vecs[i].exp_sat);
        end
        @(posedge clock); #1;
        chk("table/sat_count", 32'(sat_count), 5);

        // write coincident with an input handshake on the same channel
        in_valid    = 1'b1;
        in_channel  = 2'd0;
        in_data     = 16'sd100;
        gain_enable = 1'b1;
        cal_we      = 1'b1;
        cal_address = 3'd0;
        cal_data    = 16'd50;
        @(posedge clock); #1;
        in_valid = 1'b0;
        cal_we   = 1'b0;
        @(posedge clock); #1;
        chk("coincide/valid", 32'(out_valid), 1);
        chk("coincide/old_coef", 32'($signed(out_data)), 100);
        send("coincide_next", 0, 100, 1'b1, 150, 0);
        cal_write(0, 0);

        // backpressure: out_ready low for the first three cycles
        begin
            int  idx      = 0;
            int  oidx     = 0;
            int  extra    = 0;
            bit  saw_full = 0;
            bit  hs_in;
            gain_enable = 1'b0;
            for (int cyc = 0; cyc < 40; cyc++) begin
                out_ready = (cyc >= 3);
                if (idx < 4) begin
                    in_valid   = 1'b1;
                    in_channel = 2'(idx);
                    in_data    = 16'(bp_d[idx]);
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                hs_in = in_valid && in_ready;
                if (in_valid && !in_ready) saw_full = 1;
                if (out_valid && out_ready) begin
                    if (oidx < 4) begin
                        chk($sformatf("bp/data%0d", oidx), 32'($signed(out_data)), bp_exp[oidx]);
                        chk($sformatf("bp/chan%0d", oidx), 32'(out_channel), oidx);
                    end else begin
                        extra++;
                    end
                    oidx++;
                end
                @(posedge clock); #1;
                if (hs_in) idx++;
            end
            in_valid = 1'b0;
            chk("bp/in_ready_stall", 32'(saw_full), 1);
            chk("bp/out_count", oidx, 4);
            chk("bp/extra_outputs", extra, 0);
        end
        out_ready   = 1'b1;
        gain_enable = 1'b1;
        chk("bp/sat_count", 32'(sat_count), 5);

        // flush with two samples in flight and a coincident input
        in_valid   = 1'b1;
        in_channel = 2'd0;
        in_data    = 16'sd7;
        @(posedge clock); #1;
        in_channel = 2'd1;
        in_data    = 16'sd8;
        @(posedge clock); #1;
        out_ready      = 1'b0;
        pipeline_flush = 1'b1;
        in_channel     = 2'd2;
        in_data        = 16'sd9;
        #1;
        chk("flush/in_ready", 32'(in_ready), 1);
        @(posedge clock); #1;
        pipeline_flush = 1'b0;
        in_valid       = 1'b0;
        out_ready      = 1'b1;
        begin
            bit seen = 0;
            for (int k = 0; k < 4; k++) begin
                if (out_valid) seen = 1;
                @(posedge clock); #1;
            end
            chk("flush/no_out_valid", 32'(seen), 0);
        end
        chk("flush/sat_count", 32'(sat_count), 5);
        send("flush/ch1_kept", 1, -100, 1'b1, 412, 0);
        send("flush/ch2_kept", 2, 3, 1'b1, 5, 0);

        // async reset mid-stream
        in_valid   = 1'b1;
        in_channel = 2'd0;
        in_data    = 16'sd1000;
        @(posedge clock); #1;
        in_data = 16'sd2000;
        @(posedge clock); #1;
        chk("midrst/pre_valid", 32'(out_valid), 1);
        #2 reset = 1'b1;
        #1;
        in_valid = 1'b0;
        chk("midrst/out_valid", 32'(out_valid), 0);
        chk("midrst/out_data", 32'($signed(out_data)), 0);
        chk("midrst/out_channel", 32'(out_channel), 0);
        chk("midrst/sat_count", 32'(sat_count), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        chk("midrst/idle", 32'(out_valid), 0);
        send("midrst/gain_one", 2, 3, 1'b1, 3, 0);
        send("midrst/offset_zero", 1, 32512, 1'b1, 32512, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
